// File: rtl/mux_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mux_scan -- registered channel mux with manual single-shot and auto scan    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module mux_scan #(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int DWELL = 4,
  localparam int SELW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*WIDTH-1:0]   in_i,
  input  logic [SELW-1:0]        sel_i,
  input  logic                   mode_i,
  input  logic [NCH-1:0]         en_mask_i,
  input  logic                   start_i,
  output logic [WIDTH-1:0]       out_o,
  output logic [SELW-1:0]        out_ch_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic                   sel_err_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  localparam logic [7:0]      DWELL_LAST = 8'(DWELL - 1);
  localparam logic [SELW:0]   NCH_W      = (SELW + 1)'(NCH);

  // Out-of-range indices read as zero, which is also the manual sel_err payload.
  function automatic logic [WIDTH-1:0] f_chan(input logic [NCH*WIDTH-1:0] bus,
                                               input logic [SELW-1:0]      idx);
    f_chan = '0;
    for (int k = 0; k < NCH; k++) begin
      if (SELW'(k) == idx) f_chan = bus[k*WIDTH +: WIDTH];
    end
  endfunction

  function automatic logic [SELW-1:0] f_first(input logic [NCH-1:0] mask);
    f_first = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k]) f_first = SELW'(k);
    end
  endfunction

  // Lowest enabled channel above ptr, else wrap to the lowest enabled overall.
  function automatic logic [SELW-1:0] f_next(input logic [NCH-1:0] mask,
                                             input logic [SELW-1:0] ptr);
    logic [SELW-1:0] v_low;
    logic [SELW-1:0] v_above;
    logic            v_found;
    v_low   = ptr;
    v_above = ptr;
    v_found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k]) begin
        v_low = SELW'(k);
        if (k > int'(ptr)) begin
          v_above = SELW'(k);
          v_found = 1'b1;
        end
      end
    end
    f_next = v_found ? v_above : v_low;
  endfunction

  logic [1:0]       state_q,     state_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;
  logic [7:0]       dwell_q,     dwell_d;
  logic [WIDTH-1:0] out_q,       out_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q,   sel_err_d;
  logic             auto_q,      auto_d;

  logic             w_sel_ok;
  assign w_sel_ok = ({1'b0, sel_i} < NCH_W);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dwell_d     = dwell_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    auto_d      = auto_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (!mode_i) begin
            out_d       = f_chan(in_i, sel_i);
            out_ch_d    = sel_i;
            out_valid_d = 1'b1;
            auto_d      = 1'b0;
            state_d     = S_PRESENT;
            if (!w_sel_ok) sel_err_d = 1'b1;
          end else if (|en_mask_i) begin
            ptr_d   = f_first(en_mask_i);
            dwell_d = '0;
            auto_d  = 1'b1;
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (dwell_q == DWELL_LAST) begin
          out_d       = f_chan(in_i, ptr_q);
          out_ch_d    = ptr_q;
          out_valid_d = 1'b1;
          state_d     = S_PRESENT;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      S_PRESENT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (auto_q && mode_i && (|en_mask_i)) begin
            ptr_d   = f_next(en_mask_i, ptr_q);
            dwell_d = '0;
            state_d = S_SETTLE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      dwell_q     <= '0;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      auto_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dwell_q     <= dwell_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      auto_q      <= auto_d;
    end
  end

  assign out_o       = out_q;
  assign out_ch_o    = out_ch_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q != S_IDLE);
  assign sel_err_o   = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// Directed bench for mux_scan: WIDTH=1/NCH=8 main instance plus NCH=4 and NCH=3 select-range instances.
module tb_mux_scan;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_a;
  logic [2:0] sel_a;
  logic       mode_a;
  logic [7:0] mask_a;
  logic       start_a;
  logic       ready_a;
  logic [0:0] out_a;
  logic [2:0] ch_a;
  logic       valid_a, busy_a, err_a;

  logic        rst2_n;
  logic [31:0] in_b;
  logic [23:0] in_c;
  logic [1:0]  sel_b;
  logic        mode_b, start_b, ready_b;
  logic [3:0]  mask_b;
  logic [2:0]  mask_c;
  logic [7:0]  out_b, out_c;
  logic [1:0]  ch_b, ch_c;
  logic        valid_b, busy_b, err_b, valid_c, busy_c, err_c;

  int n_pass = 0;
  int n_tot  = 0;

  mux_scan #(.WIDTH(1), .NCH(8), .DWELL(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_i(in_a), .sel_i(sel_a), .mode_i(mode_a),
    .en_mask_i(mask_a), .start_i(start_a), .out_o(out_a), .out_ch_o(ch_a),
    .out_valid_o(valid_a), .out_ready_i(ready_a), .busy_o(busy_a), .sel_err_o(err_a)
  );

  mux_scan #(.WIDTH(8), .NCH(4), .DWELL(4)) u_b (
    .clk(clk), .rst_n(rst2_n), .in_i(in_b), .sel_i(sel_b), .mode_i(mode_b),
    .en_mask_i(mask_b), .start_i(start_b), .out_o(out_b), .out_ch_o(ch_b),
    .out_valid_o(valid_b), .out_ready_i(ready_b), .busy_o(busy_b), .sel_err_o(err_b)
  );

  mux_scan #(.WIDTH(8), .NCH(3), .DWELL(4)) u_c (
    .clk(clk), .rst_n(rst2_n), .in_i(in_c), .sel_i(sel_b), .mode_i(mode_b),
    .en_mask_i(mask_c), .start_i(start_b), .out_o(out_c), .out_ch_o(ch_c),
    .out_valid_o(valid_c), .out_ready_i(ready_b), .busy_o(busy_c), .sel_err_o(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [2:0] exp_ch [4];
  logic       exp_bit [3];

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    in_a = 8'b11010101; sel_a = '0; mode_a = 1'b0; mask_a = '0; start_a = 1'b0; ready_a = 1'b1;
    in_b = 32'hA1B2C3D4; in_c = 24'hC3D4E5; sel_b = '0; mode_b = 1'b0;
    mask_b = '0; mask_c = '0; start_b = 1'b0; ready_b = 1'b1;
    tick(); tick();
    check("rst_out",   out_a,   0);
    check("rst_ch",    ch_a,    0);
    check("rst_valid", valid_a, 0);
    check("rst_busy",  busy_a,  0);
    check("rst_err",   err_a,   0);
    rst_n = 1'b1; rst2_n = 1'b1;
    tick();

    // Manual single-shot, one-cycle valid pulse, value retained after handshake
    exp_bit[0] = 1'b1; exp_bit[1] = 1'b0; exp_bit[2] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel_a = 3'(s); start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("man_out",   out_a,   exp_bit[s]);
      check("man_ch",    ch_a,    s);
      check("man_valid", valid_a, 1);
      check("man_busy",  busy_a,  1);
      tick();
      check("man_valid_drop", valid_a, 0);
      check("man_idle",       busy_a,  0);
      check("man_retain",     out_a,   exp_bit[s]);
    end

    // Backpressure: held for 6 cycles; a start while busy is ignored
    sel_a = 3'd5; ready_a = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", valid_a, 1);
      check("bp_out",   out_a,   0);
      check("bp_ch",    ch_a,    5);
      if (i == 2) begin sel_a = 3'd0; start_a = 1'b1; end
      tick();
      start_a = 1'b0;
    end
    check("bp_valid6", valid_a, 1);
    check("bp_ch6",    ch_a,    5);
    ready_a = 1'b1;
    tick();
    check("bp_done_valid", valid_a, 0);
    check("bp_done_busy",  busy_a,  0);

    // Auto scan over channels 0,2,7 with wrap
    exp_ch[0] = 3'd0; exp_ch[1] = 3'd2; exp_ch[2] = 3'd7; exp_ch[3] = 3'd0;
    mode_a = 1'b1; mask_a = 8'b10000101; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int d = 0; d < 4; d++) begin
        check("scan_settle_valid", valid_a, 0);
        check("scan_settle_busy",  busy_a,  1);
        if (c == 1 && d == 1) sel_a = 3'd6;
        tick();
      end
      check("scan_valid", valid_a, 1);
      check("scan_ch",    ch_a,    exp_ch[c]);
      check("scan_out",   out_a,   1);
      if (c == 3) mode_a = 1'b0;
      tick();
    end
    check("scan_stop_busy",   busy_a,  0);
    check("scan_stop_valid",  valid_a, 0);
    check("scan_stop_retain", out_a,   1);

    // Asynchronous reset mid-SETTLE
    mode_a = 1'b1; mask_a = 8'b00000101; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    check("pre_rst_busy", busy_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", valid_a, 0);
    check("async_busy",  busy_a,  0);
    check("async_out",   out_a,   0);
    check("async_ch",    ch_a,    0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_valid", valid_a, 0);
      check("post_rst_busy",  busy_a,  0);
    end

    // Auto mode with empty mask is ignored
    mask_a = 8'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("empty_busy",  busy_a,  0);
    check("empty_valid", valid_a, 0);
    tick();
    check("empty_busy2", busy_a, 0);

    // Single enabled channel keeps rescanning itself, empty mask ends scan
    mask_a = 8'b00001000; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 2; c++) begin
      repeat (4) tick();
      check("single_valid", valid_a, 1);
      check("single_ch",    ch_a,    3);
      check("single_out",   out_a,   0);
      if (c == 1) mask_a = 8'b0;
      tick();
    end
    check("single_end_busy", busy_a, 0);
    check("err_never",       err_a,  0);

    // Select range: NCH=4 accepts sel=3, NCH=3 flags it sticky
    mode_b = 1'b0; sel_b = 2'd3; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("n4_out",   out_b,   8'hA1);
    check("n4_err",   err_b,   0);
    check("n3_out",   out_c,   0);
    check("n3_ch",    ch_c,    3);
    check("n3_valid", valid_c, 1);
    check("n3_err",   err_c,   1);
    tick();
    sel_b = 2'd2; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("n3_ok_out",  out_c, 8'hC3);
    check("n3_sticky",  err_c, 1);
    repeat (3) tick();
    check("n3_sticky2", err_c, 1);
    #2 rst2_n = 1'b0;
    #1;
    check("n3_err_rst", err_c, 0);
    check("n3_out_rst", out_c, 0);
    #1 rst2_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
